// File: rtl/sync_cond_pkg.sv
// Shared defaults and helpers for the sync conditioner block.
package sync_cond_pkg;

  // Defaults sized for a 50 MHz system clock (20 ms measurement window).
  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DEF_WINDOW     = 1000000;
  localparam int unsigned DEF_CNT_W      = 20;
  localparam int unsigned DEF_FILTER_LEN = 8;
  localparam int unsigned DEF_HYST       = 2;

  // Outcome of comparing the high and low duty counters at a window end.
  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_POS  = 2'd1,
    DEC_NEG  = 2'd2
  } decision_e;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    if (value > 1) begin
      for (int i = 0; i < 32; i++) begin
        if (((value - 1) >> i) != 0) r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_channel.sv
// One sync input: 2-FF synchroniser, stability filter, duty measurement,
// polarity decision with hysteresis and the normalised output register.
module sync_channel
  import sync_cond_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned HYST       = DEF_HYST
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  input  logic win_end_i,
  output logic sync_o,
  output logic pol_o,
  output logic active_o,
  output logic pol_changed_o
);

  localparam int unsigned FLT_W  = clog2(FILTER_LEN + 1);
  localparam int unsigned HYST_W = clog2(HYST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync1_q, sync2_q;
  logic f;      // filtered level this cycle
  logic f_nxt;  // filtered level next cycle

  // Two-flop synchroniser for the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync_i;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign f     = sync2_q;
      assign f_nxt = sync1_q;
    end else begin : g_filter
      logic             f_q, f_d;
      logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

      // Accept a new level only after FILTER_LEN consecutive differing samples.
      always_comb begin
        f_d       = f_q;
        flt_cnt_d = '0;
        if (sync2_q != f_q) begin
          if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) f_d = sync2_q;
          else flt_cnt_d = flt_cnt_q + FLT_W'(1);
        end
      end

      // Filter state registers.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          f_q       <= 1'b0;
          flt_cnt_q <= '0;
        end else begin
          f_q       <= f_d;
          flt_cnt_q <= flt_cnt_d;
        end
      end

      assign f     = f_q;
      assign f_nxt = f_d;
    end
  endgenerate

  logic [CNT_W-1:0]  hi_q, lo_q, hi_s, lo_s;
  logic              edge_q, edge_s;
  logic [HYST_W-1:0] hyst_q, hyst_d;
  logic              pol_q, pol_d;
  logic              active_q, pc_q, sync_q;
  logic              flip;
  logic              opposite, matching;
  decision_e         dec;

  // Counters including the current sample, so the window-end cycle counts in the closing window.
  always_comb begin
    hi_s = hi_q;
    lo_s = lo_q;
    if (f) begin
      if (hi_q != CNT_MAX) hi_s = hi_q + CNT_W'(1);
    end else begin
      if (lo_q != CNT_MAX) lo_s = lo_q + CNT_W'(1);
    end
  end

  assign edge_s = edge_q | (f_nxt != f);

  // Polarity decision: shorter level is the pulse; ties and idle windows decide nothing.
  always_comb begin
    dec = DEC_NONE;
    if (edge_s && (hi_s < lo_s)) dec = DEC_POS;
    else if (edge_s && (hi_s > lo_s)) dec = DEC_NEG;
  end

  assign opposite = ((dec == DEC_POS) && !pol_q) || ((dec == DEC_NEG) && pol_q);
  assign matching = (dec != DEC_NONE) && !opposite;

  // Hysteresis: HYST consecutive opposite decisions flip polarity.
  always_comb begin
    hyst_d = hyst_q;
    flip   = 1'b0;
    if (win_end_i) begin
      if (opposite) begin
        if (hyst_q == HYST_W'(HYST - 1)) begin
          flip   = 1'b1;
          hyst_d = '0;
        end else begin
          hyst_d = hyst_q + HYST_W'(1);
        end
      end else if (matching) begin
        hyst_d = '0;
      end
    end
  end

  assign pol_d = pol_q ^ flip;

  // Measurement, polarity and output registers; output uses the next polarity so a flip lands together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q     <= '0;
      lo_q     <= '0;
      edge_q   <= 1'b0;
      hyst_q   <= '0;
      pol_q    <= 1'b1;
      active_q <= 1'b0;
      pc_q     <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      if (win_end_i) begin
        hi_q     <= '0;
        lo_q     <= '0;
        edge_q   <= 1'b0;
        active_q <= edge_s;
      end else begin
        hi_q   <= hi_s;
        lo_q   <= lo_s;
        edge_q <= edge_s;
      end
      hyst_q <= hyst_d;
      pol_q  <= pol_d;
      pc_q   <= flip;
      sync_q <= f ^ ~pol_d;
    end
  end

  assign sync_o        = sync_q;
  assign pol_o         = pol_q;
  assign active_o      = active_q;
  assign pol_changed_o = pc_q;

endmodule

// File: rtl/sync_conditioner.sv
// Multi-channel sync polarity normaliser: shared measurement window plus
// one independent conditioning channel per sync input.
module sync_conditioner
  import sync_cond_pkg::*;
#(
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned WINDOW     = DEF_WINDOW,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned HYST       = DEF_HYST
) (
  input  logic                clk_50mhz_in,
  input  logic                reset_in,
  input  logic [CHANNELS-1:0] sync_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] sync_out_x,
  output logic [CHANNELS-1:0] positive_polarity_out,
  output logic [CHANNELS-1:0] active_out,
  output logic [CHANNELS-1:0] polarity_changed
);

  localparam int unsigned WIN_W = clog2(WINDOW);

  logic [WIN_W-1:0] win_q, win_d;
  logic             win_end;

  assign win_end = (win_q == WIN_W'(WINDOW - 1));

  // Window counter wraps 0..WINDOW-1.
  always_comb begin
    win_d = win_end ? '0 : win_q + WIN_W'(1);
  end

  // Window counter register; reset restarts the window.
  always_ff @(posedge clk_50mhz_in) begin
    if (reset_in) win_q <= '0;
    else          win_q <= win_d;
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sync_channel #(
        .CNT_W      (CNT_W),
        .FILTER_LEN (FILTER_LEN),
        .HYST       (HYST)
      ) u_ch (
        .clk_i         (clk_50mhz_in),
        .rst_i         (reset_in),
        .sync_i        (sync_in[c]),
        .win_end_i     (win_end),
        .sync_o        (sync_out[c]),
        .pol_o         (positive_polarity_out[c]),
        .active_o      (active_out[c]),
        .pol_changed_o (polarity_changed[c])
      );
    end
  endgenerate

  assign sync_out_x = ~sync_out;

endmodule

// File: doc/sync_conditioner.md
Name: sync_conditioner

Overview:
- Multi-channel successor to the per-signal sync polarity detection and inversion in the top level.
- Per channel it synchronises, deglitches and measures one sync input, then decides polarity with hysteresis and flags activity.
- It outputs the sync in a normalised polarity (active-high and active-low copies).
- Feeds video_format_detector and the monitor interface. Instantiated once for all HSYNC/VSYNC/CSYNC inputs.

Parameters:
CHANNELS, 2, number of independent sync inputs
WINDOW, 1000000, measurement window in clk cycles (20 ms at 50 MHz); must be at least 4
CNT_W, 20, width of the per-channel high/low duty counters; they saturate
FILTER_LEN, 8, cycles an input must be stable before a level change is accepted; 0 = bypass
HYST, 2, consecutive windows with an opposite decision needed to flip polarity; must be at least 1

Ports:
clk_50mhz_in  input  1  system clock, 50 MHz
reset_in  input  1  synchronous reset, active-high
sync_in  input  CHANNELS  raw asynchronous sync inputs, unknown polarity
sync_out  output  CHANNELS  normalised sync, 1 during the sync pulse
sync_out_x  output  CHANNELS  bitwise inverse of sync_out
positive_polarity_out  output  CHANNELS  1 = input pulse is high-going
active_out  output  CHANNELS  1 = at least one edge seen in the last completed window
polarity_changed  output  CHANNELS  one-cycle pulse when positive_polarity_out flips

Behaviour:
Reset (reset_in high at a clock edge, all state):
- sync_out=0, sync_out_x=1, positive_polarity_out=all 1, active_out=0, polarity_changed=0.
- Synchroniser FFs, filter state, window counter, duty counters and hysteresis counters cleared.
- Reset mid-window discards the partial window; the next window starts on the first cycle after reset deasserts.

Input path, per channel:
- 2-FF synchroniser, then filter.
- Filter: filtered level f changes only after the synchronised level differs from f for FILTER_LEN consecutive cycles. Its counter clears whenever the sample equals f.
- FILTER_LEN=0: f = synchronised level.
- Latency from sync_in edge to sync_out edge: 2+FILTER_LEN+1 cycles (FILTER_LEN=0: 3 cycles).
- sync_out = f XOR ~positive_polarity_out, registered.

Measurement:
- One shared window counter runs 0..WINDOW-1 and wraps; the cycle at WINDOW-1 is the "window end".
- Per channel, hi_cnt and lo_cnt increment on f=1 and f=0 respectively, saturating at 2^CNT_W-1.
- Per channel, edge_seen is set on any change of f.
- At window end the channel compares its counters. The decision is positive when hi_cnt < lo_cnt, negative when hi_cnt > lo_cnt, and "no decision" on a tie or when edge_seen=0.
- A decision opposite to the current polarity increments hyst_cnt. A matching decision clears it. "No decision" leaves it unchanged.
- When hyst_cnt reaches HYST: positive_polarity_out toggles on the cycle after window end, polarity_changed pulses for that same single cycle, and hyst_cnt clears.
- active_out is loaded from edge_seen at window end, so it updates on the cycle after window end.
- On the cycle after window end, hi_cnt, lo_cnt and edge_seen restart counting from the current f. No sample is lost: the window-end sample counts in the old window.
- When inactive (constant input), polarity holds and sync_out follows the constant level.

Simultaneous events:
- The channels are fully independent; several may flip in the same cycle.
- An input edge on the window-end cycle counts towards the closing window.
- A polarity flip takes effect on sync_out on the same cycle as positive_polarity_out changes. This causes one glitch edge, which is acceptable; downstream qualifies it with polarity_changed.

Decomposition:
- Package sync_cond_pkg: default constants (window for 50 MHz, FILTER_LEN, HYST) and a function clog2 for counter widths.
- Sub-module sync_channel: synchroniser, filter, duty counters, hysteresis and output register for one channel.
- The top block holds the shared window counter and a generate loop over CHANNELS.

Test Plan:
All scenarios use WINDOW=1000, FILTER_LEN=4, HYST=2, CHANNELS=2 unless stated.
1. Reset, then ch0 pulses high 50 of every 500 cycles -> positive_polarity_out[0] stays 1, active_out[0]=1 from cycle after first window end, sync_out[0] = input delayed 7 cycles, polarity_changed never pulses.
2. ch1 low 50 of every 500 cycles -> first window end: hyst_cnt=1, no flip; second window end: positive_polarity_out[1]=0, polarity_changed[1] one-cycle pulse, sync_out[1] high during the low pulses.
3. 3-cycle glitches on ch0 while otherwise constant 0 -> sync_out[0] never changes, active_out[0]=0 after the window end.
4. Hysteresis: alternate polarity every window on ch0 -> no flip. One opposite window then a matching window, repeated -> hyst_cnt returns to 0, no flip.
5. Exactly 500 high / 500 low in a window -> tie, no decision, polarity and hyst_cnt unchanged.
6. Assert reset_in for 1 cycle at window count 600 -> all outputs at reset values next cycle; the next window end occurs 1000 cycles after reset deasserts; CNT_W=8 run shows the counters saturate at 255 without wrapping.
